fp_vector_mult_stream: RTL and testbench
========================================

Name: fp_vector_mult_stream

Overview:
- Streaming element-wise FP32 vector multiplier, NUM_LANES lanes wide, with full valid/ready handshakes on both input and output.
- Replaces free-running fixed-latency vector multiply in the LCMV datapath wherever the consumer can stall (e.g. feeding matrix-inverse or accumulator stages).
- Wraps one fp_multiplier per lane, adds an operand-mode select and a credit-controlled result FIFO, so backpressure never drops or reorders results.

Parameters:
- WIDTH, 32, element width in bits (IEEE-754 single).
- NUM_LANES, 5, number of parallel lanes.
- LATENCY, 8, fp_multiplier pipeline depth in cycles.
- FIFO_DEPTH, 16, result FIFO entries; must be >= LATENCY+1 (elaboration error otherwise).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- in_a  in  WIDTH*NUM_LANES  operand A; lane i at bits [(i+1)*WIDTH-1 : i*WIDTH].
- in_b  in  WIDTH*NUM_LANES  operand B, same packing.
- in_mode  in  2  operation select, sampled with the beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_o  out  WIDTH*NUM_LANES  result vector.
- out_valid  out  1  out_o holds a result.
- out_ready  in  1  consumer takes the result.
- busy  out  1  any beat in flight or buffered.

Behaviour:
- Reset:
  - rst low clears all state immediately: in-flight valid pipe, FIFO pointers, count and credit.
  - While rst is low: in_ready=0, out_valid=0, busy=0, out_o=0.
  - First edge after release: in_ready=1.
  - Reset mid-operation discards all in-flight and buffered beats; no stale result ever appears afterwards.
- Accept: a beat is accepted on an edge where in_valid and in_ready are both 1. in_a, in_b and in_mode are ignored otherwise.
- Modes, applied to operands before the multipliers:
  - 00: o[i] = a[i]*b[i].
  - 01: o[i] = a[i]*a[i].
  - 10: o[i] = a[i]*b[0] (broadcast lane 0 of B).
  - 11: reserved, behaves as 00.
- Pipeline:
  - A LATENCY-deep valid shift register tracks accepted beats; multipliers never stall.
  - A result leaves the pipe LATENCY edges after acceptance and is written into the FIFO.
- FIFO:
  - First-word-fall-through, FIFO_DEPTH entries, pointers wrap modulo FIFO_DEPTH.
  - out_valid = (count != 0); out_o = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop on the same edge leaves count unchanged.
- Latency: with an empty FIFO and out_ready=1, out_valid rises exactly LATENCY+1 edges after the accepting edge.
- Credit:
  - occupancy = in_flight + count, range 0..FIFO_DEPTH.
  - in_ready = (occupancy < FIFO_DEPTH), registered. It is computed from next-state occupancy so it is correct the cycle after each accept or pop.
  - Accept and pop on the same edge leave occupancy unchanged.
  - The FIFO can never overflow. Overflow is an assertion failure in simulation.
- Throughput: one beat per cycle sustained when out_ready is held at 1.
- busy = (occupancy != 0).
- Ordering: results always leave in acceptance order.
- Arithmetic (rounding, NaN/Inf/denormal handling) is exactly that of fp_multiplier.

Optional Feature:
- Macro: FP_VMUL_LANE_MASK_EN.
- Defined:
  - Adds port in_mask (in, NUM_LANES), sampled with the beat and carried down the pipe alongside valid.
  - Lanes with mask bit 0 produce +0.0 (all-zero word) at the output, regardless of operands.
- Undefined: no in_mask port; all lanes are active.

Test Plan:
- Mode 00, lane 0 a=0x40000000 (2.0), b=0x40400000 (3.0), out_ready=1 -> out lane 0 = 0x40C00000 (6.0), out_valid rises exactly 9 edges after accept (LATENCY=8).
- Mode 01, a lanes = 3.0, 1.5, -2.0, 0.0, 1.0 -> 0x41100000, 0x40100000, 0x40800000, 0x00000000, 0x3F800000; b values ignored.
- Mode 10, a = {1,2,3,4,5}, b[0]=0.5, other b lanes = NaN -> {0.5,1.0,1.5,2.0,2.5}, no NaN in any lane.
- out_ready=0, in_valid=1 with incrementing lane 0 values for 20 cycles -> exactly 16 accepts, then in_ready=0. Raise out_ready -> 16 results in order, none lost or duplicated; in_ready returns the cycle after the first pop.
- Continuous input with random out_ready (50%) for 1000 beats -> scoreboard matches in order; in_ready and out_valid never form an overflow or underflow.
- rst pulsed low with 5 beats in flight and 3 buffered -> out_valid=0 and busy=0 immediately. After release, a new beat yields only its own result.

Source files
------------

// File: rtl/fp_vector_mult_stream_if.sv
// Stream bundle for fp_vector_mult_stream: input beat handshake, result handshake and busy.
// Carries in_mask only when FP_VMUL_LANE_MASK_EN is defined.
interface fp_vector_mult_stream_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_LANES = 5
);
    logic [WIDTH*NUM_LANES-1:0] in_a;
    logic [WIDTH*NUM_LANES-1:0] in_b;
    logic [1:0]                 in_mode;
    logic                       in_valid;
    logic                       in_ready;
`ifdef FP_VMUL_LANE_MASK_EN
    logic [NUM_LANES-1:0]       in_mask;
`endif
    logic [WIDTH*NUM_LANES-1:0] out_o;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;

`ifdef FP_VMUL_LANE_MASK_EN
    modport slave (
        input  in_a, in_b, in_mode, in_valid, in_mask, out_ready,
        output in_ready, out_o, out_valid, busy
    );
    modport master (
        output in_a, in_b, in_mode, in_valid, in_mask, out_ready,
        input  in_ready, out_o, out_valid, busy
    );
`else
    modport slave (
        input  in_a, in_b, in_mode, in_valid, out_ready,
        output in_ready, out_o, out_valid, busy
    );
    modport master (
        output in_a, in_b, in_mode, in_valid, out_ready,
        input  in_ready, out_o, out_valid, busy
    );
`endif
endinterface

// File: rtl/fp_vector_mult_stream.sv
// Streaming element-wise FP32 vector multiplier with credit-controlled FWFT result FIFO.
// Optional per-lane zeroing mask enabled by defining FP_VMUL_LANE_MASK_EN.
module fp_vector_mult_stream #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_LANES  = 5,
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fp_vector_mult_stream_if.slave  bus
);
    localparam int unsigned VEC_W = WIDTH * NUM_LANES;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
        $error("fp_vector_mult_stream: FIFO_DEPTH must be >= LATENCY+1");
    end

    // IEEE-754 single multiply, round-to-nearest-even, denormals flushed to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic [7:0]        ea, eb;
        logic [22:0]       fa, fb, frac;
        logic [47:0]       prod;
        logic              grd, stk;
        logic [23:0]       rnd;
        logic signed [10:0] e;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]       res;
        sgn    = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
        e      = $signed(11'(ea)) + $signed(11'(eb)) - 11'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            grd  = prod[23];
            stk  = |prod[22:0];
            e    = e + 11'sd1;
        end else begin
            frac = prod[45:23];
            grd  = prod[22];
            stk  = |prod[21:0];
        end
        rnd = {1'b0, frac} + 24'(grd & (stk | frac[0]));
        if (rnd[23]) begin
            e = e + 11'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            res = {sgn, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            res = {sgn, 31'h0};
        end else if (e >= 11'sd255) begin
            res = {sgn, 8'hFF, 23'h0};
        end else if (e <= 11'sd0) begin
            res = {sgn, 31'h0};
        end else begin
            res = {sgn, e[7:0], rnd[22:0]};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [LATENCY:0]       vld_q, vld_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d, occ_q, occ_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;

    logic [VEC_W-1:0]       op_a_q, op_b_q;
    logic [VEC_W-1:0]       res_q [LATENCY];
    logic [NUM_LANES-1:0]   msk_q [LATENCY+1];
    logic [VEC_W-1:0]       mem_q [FIFO_DEPTH];

    logic                   accept_c, pop_c, push_c;
    logic [VEC_W-1:0]       op_b_c, prod_c, push_data_c;
    logic [NUM_LANES-1:0]   mask_in_c;

    assign accept_c = bus.in_valid && in_ready_q;
    assign pop_c    = out_valid_q && bus.out_ready;
    assign push_c   = vld_q[LATENCY];

`ifdef FP_VMUL_LANE_MASK_EN
    assign mask_in_c = bus.in_mask;
`else
    assign mask_in_c = '1;
`endif

    // Operand-mode select: 01 squares A, 10 broadcasts B lane 0, 11 falls back to 00.
    always_comb begin
        op_b_c = bus.in_b;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            case (bus.in_mode)
                2'b01:   op_b_c[i*WIDTH +: WIDTH] = bus.in_a[i*WIDTH +: WIDTH];
                2'b10:   op_b_c[i*WIDTH +: WIDTH] = bus.in_b[WIDTH-1:0];
                default: op_b_c[i*WIDTH +: WIDTH] = bus.in_b[i*WIDTH +: WIDTH];
            endcase
        end
    end

    always_comb begin
        prod_c      = '0;
        push_data_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            prod_c[i*WIDTH +: WIDTH] = fmul(op_a_q[i*WIDTH +: WIDTH], op_b_q[i*WIDTH +: WIDTH]);
            push_data_c[i*WIDTH +: WIDTH] = msk_q[LATENCY][i] ?
                                            res_q[LATENCY-1][i*WIDTH +: WIDTH] : '0;
        end
    end

    // Datapath never stalls; vld_q alone decides which stages carry real beats.
    always_ff @(posedge clk) begin
        op_a_q   <= bus.in_a;
        op_b_q   <= op_b_c;
        msk_q[0] <= mask_in_c;
        res_q[0] <= prod_c;
        for (int k = 1; k < int'(LATENCY); k++) begin
            res_q[k] <= res_q[k-1];
        end
        for (int k = 1; k <= int'(LATENCY); k++) begin
            msk_q[k] <= msk_q[k-1];
        end
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

    // Occupancy counts in-flight plus buffered beats; it is the credit that gates in_ready.
    always_comb begin
        vld_d       = {vld_q[LATENCY-1:0], accept_c};
        wr_ptr_d    = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        occ_d       = occ_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
        if (accept_c && !pop_c) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!accept_c && pop_c) begin
            occ_d = occ_q - CNT_W'(1);
        end
        in_ready_d  = (occ_d < CNT_W'(FIFO_DEPTH));
        out_valid_d = (count_d != '0);
        busy_d      = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_o     = out_valid_q ? mem_q[rd_ptr_q] : '0;

    always @(posedge clk) begin
        if (rst && push_c && !pop_c) begin
            assert (count_q < CNT_W'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_fp_vector_mult_stream.sv
// Directed bench for fp_vector_mult_stream: modes, latency, backpressure, random drain, reset.
// With FP_VMUL_LANE_MASK_EN defined the mask is held all-ones.
module tb_fp_vector_mult_stream;
    localparam int unsigned W  = 32;
    localparam int unsigned NL = 5;
    localparam int unsigned VW = W * NL;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fp_vector_mult_stream_if #(.WIDTH(W), .NUM_LANES(NL)) bus ();

    fp_vector_mult_stream #(
        .WIDTH(W), .NUM_LANES(NL), .LATENCY(8), .FIFO_DEPTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] vec5(input logic [31:0] l4, input logic [31:0] l3,
                                            input logic [31:0] l2, input logic [31:0] l1,
                                            input logic [31:0] l0);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [VW-1:0] rexp(input int k);
        return vec5(32'h0, 32'h0, 32'h0, 32'h4000_0000 + 32'(k), 32'h3F80_0000 + 32'(k));
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns edges from accept to out_valid.
    task automatic send_and_wait(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [1:0] mode, output logic [VW-1:0] res,
                                 output int edges);
        chk1("ready_before_send", bus.in_ready, 1'b1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = mode;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        res = bus.out_o;
    endtask

    logic [VW-1:0] res;
    int            edges, acc, sent, rcv, cyc, stray, w;
    logic          rdy;

    initial begin
        rst           = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mode   = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FP_VMUL_LANE_MASK_EN
        bus.in_mask   = '1;
`endif
        repeat (3) @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chkv("rst_out_o", bus.out_o, '0);
        rst = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);

        // Mode 00
        send_and_wait(vec5(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
                      vec5(32'h4080_0000, 32'h0000_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h4040_0000),
                      2'b00, res, edges);
        chki("m00_latency", edges, 9);
        chkv("m00_data", res,
             vec5(32'h4100_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000, 32'h40C0_0000));
        chk1("m00_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk1("m00_drained_valid", bus.out_valid, 1'b0);
        chk1("m00_drained_busy", bus.busy, 1'b0);

        // Mode 01: B is ignored
        send_and_wait(vec5(32'h3F80_0000, 32'h0000_0000, 32'hC000_0000, 32'h3FC0_0000, 32'h4040_0000),
                      vec5(32'hDEAD_BEEF, 32'h7FC0_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7F80_0000),
                      2'b01, res, edges);
        chki("m01_latency", edges, 9);
        chkv("m01_data", res,
             vec5(32'h3F80_0000, 32'h0000_0000, 32'h4080_0000, 32'h4010_0000, 32'h4110_0000));
        @(negedge clk);

        // Mode 10: NaN in B lanes 1..4 must not leak
        send_and_wait(vec5(32'h40A0_0000, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000),
                      vec5(32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3F00_0000),
                      2'b10, res, edges);
        chki("m10_latency", edges, 9);
        chkv("m10_data", res,
             vec5(32'h4020_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000));
        @(negedge clk);

        // Mode 11 behaves as 00
        send_and_wait(vec5(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
                      vec5(32'h4080_0000, 32'h0000_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h4040_0000),
                      2'b11, res, edges);
        chkv("m11_data", res,
             vec5(32'h4100_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000, 32'h40C0_0000));
        @(negedge clk);

        // Backpressure: fill to credit limit
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'b00;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = vec5(32'h0, 32'h0, 32'h0, 32'h0, 32'h3F80_0000 + 32'(acc));
            bus.in_b     = vec5(32'h0, 32'h0, 32'h0, 32'h0, 32'h3F80_0000);
            rdy = bus.in_ready;
            @(negedge clk);
            if (rdy) acc++;
        end
        bus.in_valid = 1'b0;
        chki("bp_accepts", acc, 16);
        chk1("bp_in_ready_low", bus.in_ready, 1'b0);
        repeat (12) @(negedge clk);
        chk1("bp_full_busy", bus.busy, 1'b1);
        chk1("bp_full_valid", bus.out_valid, 1'b1);
        chk1("bp_full_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk1("bp_pop_valid", bus.out_valid, 1'b1);
            chkv("bp_pop_data", bus.out_o,
                 vec5(32'h0, 32'h0, 32'h0, 32'h0, 32'h3F80_0000 + 32'(i)));
            @(negedge clk);
            if (i == 0) chk1("bp_ready_after_pop", bus.in_ready, 1'b1);
        end
        chk1("bp_empty_valid", bus.out_valid, 1'b0);
        chk1("bp_empty_busy", bus.busy, 1'b0);

        // Continuous input, random out_ready
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 1000 && cyc < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 1000);
            bus.in_a      = vec5(32'h0, 32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000 + 32'(sent));
            bus.in_b      = vec5(32'h0, 32'h0, 32'h0, 32'h3F80_0000 + 32'(sent), 32'h3F80_0000);
            if (bus.out_valid && bus.out_ready) begin
                chk1("rand_no_underflow", 1'(rcv < sent), 1'b1);
                chkv("rand_data", bus.out_o, rexp(rcv));
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chki("rand_received", rcv, 1000);
        chk1("rand_idle_busy", bus.busy, 1'b0);

        // Reset with 5 in flight and 3 buffered
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = vec5(32'h0, 32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000 + 32'(k));
            bus.in_b     = vec5(32'h0, 32'h0, 32'h0, 32'h3F80_0000 + 32'(k), 32'h3F80_0000);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk1("rr_buffered_valid", bus.out_valid, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk1("rr_out_valid", bus.out_valid, 1'b0);
        chk1("rr_busy", bus.busy, 1'b0);
        chk1("rr_in_ready", bus.in_ready, 1'b0);
        chkv("rr_out_o", bus.out_o, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_and_wait(vec5(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
                      vec5(32'h4080_0000, 32'h0000_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h4040_0000),
                      2'b00, res, edges);
        chki("rr_new_latency", edges, 9);
        chkv("rr_new_data", res,
             vec5(32'h4100_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000, 32'h40C0_0000));
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        chki("rr_no_stale", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
